// File: rtl/axi_image_pkg.sv
// Shared types and constants for the AXI image buffer slice.
package axi_image_pkg;

    // AXI write response codes used by this slave
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Write channel FSM: collecting AW/W, or presenting a B response
    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    // Pixel stream FSM
    typedef enum logic {
        S_IDLE,
        S_STREAM
    } st_state_t;

    // Bit of the CTRL word that requests a stream start
    localparam int CTRL_START_BIT = 0;

    // Expands the four byte strobes into a 32-bit bit-enable mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_wr_slave.sv
// AXI4-Lite write front end: accepts AW and W independently, issues a single
// commit strobe once both are held, and keeps BVALID/BRESP up until BREADY.
module axi_lite_wr_slave
    import axi_image_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic        commit,
    output logic [31:0] commit_addr,
    output logic [31:0] commit_data,
    output logic [3:0]  commit_strb,
    input  resp_t       commit_resp
);

    wr_state_t   state;
    logic        aw_held;
    logic        w_held;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    resp_t       bresp_q;

    // Each channel is ready while idle and its own holding latch is empty;
    // commit fires in the cycle after both latches have filled.
    always_comb begin
        AWREADY = !aw_held && (state == W_IDLE);
        WREADY  = !w_held && (state == W_IDLE);
        commit  = (state == W_IDLE) && aw_held && w_held && !ARESET;
    end

    assign commit_addr = aw_addr_q;
    assign commit_data = w_data_q;
    assign commit_strb = w_strb_q;
    assign BVALID      = bvalid_q;
    assign BRESP       = bresp_q;

    // Write FSM: latch AW/W, commit with registered response, then wait for BREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (state)
                W_IDLE: begin
                    if (aw_held && w_held) begin
                        state    <= W_RESP;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= commit_resp;
                    end else begin
                        if (AWVALID && !aw_held) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= AWADDR;
                        end
                        if (WVALID && !w_held) begin
                            w_held   <= 1'b1;
                            w_data_q <= WDATA;
                            w_strb_q <= WSTRB;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        state    <= W_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/axi_image_buffer.sv
// Image buffer for the SNN input encoder: AXI4-Lite writes fill a pixel memory,
// and a CTRL write streams the whole image out over a ready/valid interface.
// Pixel i lives at byte address 4*i; CTRL sits in the word right after the last
// pixel (0x400 for 256 pixels). Everything else answers SLVERR.
module axi_image_buffer
    import axi_image_pkg::*;
#(
    parameter int  PIXEL_W  = 8,
    parameter int  N_PIXELS = 256,
    localparam int IDX_W    = $clog2(N_PIXELS)
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [31:0]        AWADDR,
    input  logic [2:0]         AWPROT,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [31:0]        WDATA,
    input  logic [3:0]         WSTRB,
    input  logic               WVALID,
    output logic               WREADY,
    output logic [1:0]         BRESP,
    output logic               BVALID,
    input  logic               BREADY,
    output logic [PIXEL_W-1:0] PIX_DATA,
    output logic [IDX_W-1:0]   PIX_IDX,
    output logic               PIX_LAST,
    output logic               PIX_VALID,
    input  logic               PIX_READY,
    output logic               BUSY,
    output logic               IMG_DONE
);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_PIXELS - 1);
    localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(N_PIXELS - 2);
    localparam logic [29:0]      CTRL_WORD    = 30'(N_PIXELS);

    logic               commit;
    logic [31:0]        commit_addr;
    logic [31:0]        commit_data;
    logic [3:0]         commit_strb;
    resp_t              commit_resp;

    logic [29:0]        word_addr;
    logic [IDX_W-1:0]   wr_idx;
    logic               is_pixel;
    logic               is_ctrl;
    logic               pix_we;
    logic               start_req;
    logic [31:0]        byte_mask;
    logic [PIXEL_W-1:0] pix_mask;

    st_state_t          st_state;
    logic [IDX_W-1:0]   pix_idx_q;
    logic               pix_valid_q;
    logic               pix_last_q;
    logic               busy_q;
    logic               img_done_q;
    logic               pix_fire;

    logic [PIXEL_W-1:0] mem [N_PIXELS];

    logic               unused_bits;

    axi_lite_wr_slave u_wr (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .AWADDR      (AWADDR),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .commit      (commit),
        .commit_addr (commit_addr),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .commit_resp (commit_resp)
    );

    assign word_addr = commit_addr[31:2];
    assign wr_idx    = commit_addr[IDX_W+1:2];
    assign byte_mask = strb_mask(commit_strb);
    assign pix_mask  = byte_mask[PIXEL_W-1:0];

    // Protection bits, byte offset and unused data/strobe lanes carry no meaning here
    assign unused_bits = ^{AWPROT, commit_addr[1:0], commit_data, byte_mask};

    // Address decode: choose the response and the side effect of the pending commit;
    // both pixel and CTRL writes are refused while an image is streaming
    always_comb begin
        is_pixel    = (word_addr < CTRL_WORD);
        is_ctrl     = (word_addr == CTRL_WORD);
        commit_resp = RESP_SLVERR;
        pix_we      = 1'b0;
        start_req   = 1'b0;
        if (is_pixel && !busy_q) begin
            commit_resp = RESP_OKAY;
            pix_we      = commit;
        end else if (is_ctrl && !busy_q) begin
            commit_resp = RESP_OKAY;
            start_req   = commit && commit_data[CTRL_START_BIT];
        end
    end

    // Pixel memory: byte-masked write on commit, no reset so it maps onto RAM
    always_ff @(posedge ACLK) begin
        if (pix_we) begin
            mem[wr_idx] <= (mem[wr_idx] & ~pix_mask) | (commit_data[PIXEL_W-1:0] & pix_mask);
        end
    end

    assign pix_fire  = pix_valid_q && PIX_READY;
    assign PIX_DATA  = mem[pix_idx_q];
    assign PIX_IDX   = pix_idx_q;
    assign PIX_LAST  = pix_last_q;
    assign PIX_VALID = pix_valid_q;
    assign BUSY      = busy_q;
    assign IMG_DONE  = img_done_q;

    // Stream FSM: walk indices 0..N_PIXELS-1 on handshakes, pulse IMG_DONE after the last
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            st_state    <= S_IDLE;
            pix_idx_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            img_done_q  <= 1'b0;
        end else begin
            img_done_q <= 1'b0;
            case (st_state)
                S_IDLE: begin
                    if (start_req) begin
                        st_state    <= S_STREAM;
                        pix_idx_q   <= '0;
                        pix_valid_q <= 1'b1;
                        pix_last_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (pix_fire) begin
                        if (pix_idx_q == LAST_IDX) begin
                            st_state    <= S_IDLE;
                            pix_valid_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            img_done_q  <= 1'b1;
                        end else begin
                            pix_idx_q  <= pix_idx_q + IDX_W'(1);
                            pix_last_q <= (pix_idx_q == PRE_LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_image_buffer.sv
// Directed self-checking bench for axi_image_buffer (256 pixels x 8 bits).
module tb_axi_image_buffer;

    localparam int          PIXEL_W   = 8;
    localparam int          N_PIXELS  = 256;
    localparam int          IDX_W     = 8;
    localparam logic [31:0] CTRL_ADDR = 32'h0000_0400;

    logic               ACLK;
    logic               ARESET;
    logic [31:0]        AWADDR;
    logic [2:0]         AWPROT;
    logic               AWVALID;
    logic               AWREADY;
    logic [31:0]        WDATA;
    logic [3:0]         WSTRB;
    logic               WVALID;
    logic               WREADY;
    logic [1:0]         BRESP;
    logic               BVALID;
    logic               BREADY;
    logic [PIXEL_W-1:0] PIX_DATA;
    logic [IDX_W-1:0]   PIX_IDX;
    logic               PIX_LAST;
    logic               PIX_VALID;
    logic               PIX_READY;
    logic               BUSY;
    logic               IMG_DONE;

    int checks = 0;
    int errors = 0;
    logic [PIXEL_W-1:0] exp_mem [N_PIXELS];

    axi_image_buffer #(
        .PIXEL_W  (PIXEL_W),
        .N_PIXELS (N_PIXELS)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .AWADDR    (AWADDR),
        .AWPROT    (AWPROT),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .PIX_DATA  (PIX_DATA),
        .PIX_IDX   (PIX_IDX),
        .PIX_LAST  (PIX_LAST),
        .PIX_VALID (PIX_VALID),
        .PIX_READY (PIX_READY),
        .BUSY      (BUSY),
        .IMG_DONE  (IMG_DONE)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not end within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Full AXI write with AW and W presented together; returns BRESP
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int cyc;
        logic aw_go;
        logic w_go;
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = 1'b1;
        cyc     = 0;
        while ((AWVALID || WVALID) && cyc < 20) begin
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            step();
            if (aw_go) AWVALID = 1'b0;
            if (w_go)  WVALID  = 1'b0;
            cyc++;
        end
        while (!BVALID && cyc < 20) begin
            step();
            cyc++;
        end
        resp = BRESP;
        checks++;
        if (BVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL axi_write_timeout: addr=%h got BVALID=%b required 1", addr, BVALID);
            AWVALID = 1'b0;
            WVALID  = 1'b0;
        end
        step();
        BREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) step();
        checks++; if (AWREADY !== 1'b1)  begin errors++; $display("[TB] FAIL reset_awready: got %b required 1", AWREADY); end
        checks++; if (WREADY !== 1'b1)   begin errors++; $display("[TB] FAIL reset_wready: got %b required 1", WREADY); end
        checks++; if (BVALID !== 1'b0)   begin errors++; $display("[TB] FAIL reset_bvalid: got %b required 0", BVALID); end
        checks++; if (BRESP !== 2'b00)   begin errors++; $display("[TB] FAIL reset_bresp: got %b required 00", BRESP); end
        checks++; if (PIX_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_valid: got %b required 0", PIX_VALID); end
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", BUSY); end
        checks++; if (IMG_DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_img_done: got %b required 0", IMG_DONE); end
        ARESET = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [1:0] resp;
        for (int i = 0; i < N_PIXELS; i++) begin
            axi_write(32'(i * 4), 32'(i), 4'hF, resp);
            exp_mem[i] = PIXEL_W'(i);
            checks++;
            if (resp !== 2'b00) begin
                errors++;
                $display("[TB] FAIL fill_resp[%0d]: got %b required 00", i, resp);
            end
        end
    endtask

    task automatic test_independent_channels();
        // W arrives alone first
        WDATA  = 32'h0000_005A;
        WSTRB  = 4'b0001;
        WVALID = 1'b1;
        BREADY = 1'b0;
        checks++; if (WREADY !== 1'b1) begin errors++; $display("[TB] FAIL indep_wready_idle: got %b required 1", WREADY); end
        step();
        WVALID = 1'b0;
        checks++; if (WREADY !== 1'b0)  begin errors++; $display("[TB] FAIL indep_wready_held: got %b required 0", WREADY); end
        checks++; if (AWREADY !== 1'b1) begin errors++; $display("[TB] FAIL indep_awready_open: got %b required 1", AWREADY); end
        repeat (2) step();
        checks++; if (BVALID !== 1'b0)  begin errors++; $display("[TB] FAIL indep_bvalid_w_only: got %b required 0", BVALID); end
        // AW follows three cycles after W
        AWADDR  = 32'h0000_0010;
        AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        checks++; if (BVALID !== 1'b0) begin errors++; $display("[TB] FAIL indep_bvalid_commit_cycle: got %b required 0", BVALID); end
        step();
        exp_mem[4] = 8'h5A;
        checks++; if (BVALID !== 1'b1) begin errors++; $display("[TB] FAIL indep_bvalid_rise: got %b required 1", BVALID); end
        checks++; if (BRESP !== 2'b00) begin errors++; $display("[TB] FAIL indep_bresp: got %b required 00", BRESP); end
        // BREADY held low: response must persist and no new transfer is offered
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (BVALID !== 1'b1)  begin errors++; $display("[TB] FAIL indep_bvalid_hold[%0d]: got %b required 1", i, BVALID); end
            checks++; if (BRESP !== 2'b00)  begin errors++; $display("[TB] FAIL indep_bresp_hold[%0d]: got %b required 00", i, BRESP); end
            checks++; if (AWREADY !== 1'b0) begin errors++; $display("[TB] FAIL indep_awready_resp[%0d]: got %b required 0", i, AWREADY); end
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        checks++; if (BVALID !== 1'b0)  begin errors++; $display("[TB] FAIL indep_bvalid_clear: got %b required 0", BVALID); end
        checks++; if (AWREADY !== 1'b1) begin errors++; $display("[TB] FAIL indep_awready_back: got %b required 1", AWREADY); end
    endtask

    task automatic test_strobe_illegal();
        logic [1:0] resp;
        // WSTRB=0 leaves pixel 1 alone but still answers OKAY
        axi_write(32'h0000_0004, 32'h0000_00FF, 4'b0000, resp);
        checks++; if (resp !== 2'b00) begin errors++; $display("[TB] FAIL strb0_resp: got %b required 00", resp); end
        // Only byte 0 holds the 8-bit pixel, so upper strobes change nothing
        axi_write(32'h0000_0008, 32'hFFFF_FF77, 4'b1110, resp);
        checks++; if (resp !== 2'b00) begin errors++; $display("[TB] FAIL strb_upper_resp: got %b required 00", resp); end
        // 0x800 lies beyond CTRL (0x400) and is unmapped
        axi_write(32'h0000_0800, 32'h0000_0001, 4'hF, resp);
        checks++; if (resp !== 2'b10) begin errors++; $display("[TB] FAIL illegal_800_resp: got %b required 10", resp); end
        checks++; if (BUSY !== 1'b0)  begin errors++; $display("[TB] FAIL illegal_800_busy: got %b required 0", BUSY); end
        axi_write(32'h0000_0804, 32'h0000_0001, 4'hF, resp);
        checks++; if (resp !== 2'b10) begin errors++; $display("[TB] FAIL illegal_804_resp: got %b required 10", resp); end
        checks++; if (PIX_VALID !== 1'b0) begin errors++; $display("[TB] FAIL illegal_804_pix_valid: got %b required 0", PIX_VALID); end
        // CTRL with the start bit clear is accepted but does nothing
        axi_write(CTRL_ADDR, 32'h0000_0000, 4'hF, resp);
        checks++; if (resp !== 2'b00) begin errors++; $display("[TB] FAIL ctrl0_resp: got %b required 00", resp); end
        checks++; if (BUSY !== 1'b0)  begin errors++; $display("[TB] FAIL ctrl0_busy: got %b required 0", BUSY); end
    endtask

    task automatic test_full_stream();
        logic [1:0] resp;
        int count;
        int done_cnt;
        PIX_READY = 1'b0;
        axi_write(CTRL_ADDR, 32'h0000_0001, 4'hF, resp);
        checks++; if (resp !== 2'b00)      begin errors++; $display("[TB] FAIL stream_start_resp: got %b required 00", resp); end
        checks++; if (BUSY !== 1'b1)       begin errors++; $display("[TB] FAIL stream_start_busy: got %b required 1", BUSY); end
        checks++; if (PIX_VALID !== 1'b1)  begin errors++; $display("[TB] FAIL stream_start_valid: got %b required 1", PIX_VALID); end
        checks++; if (PIX_IDX !== 8'd0)    begin errors++; $display("[TB] FAIL stream_start_idx: got %0d required 0", PIX_IDX); end
        PIX_READY = 1'b1;
        count     = 0;
        done_cnt  = 0;
        for (int cyc = 0; cyc < 600 && done_cnt == 0; cyc++) begin
            if (PIX_VALID) begin
                checks++; if (PIX_IDX !== 8'(count)) begin errors++; $display("[TB] FAIL stream_idx: got %0d required %0d", PIX_IDX, count); end
                checks++; if (PIX_DATA !== exp_mem[count % N_PIXELS]) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h required %h", count, PIX_DATA, exp_mem[count % N_PIXELS]); end
                checks++; if (PIX_LAST !== 1'(count == N_PIXELS - 1)) begin errors++; $display("[TB] FAIL stream_last[%0d]: got %b", count, PIX_LAST); end
                count++;
            end
            step();
            if (IMG_DONE) begin
                done_cnt++;
                checks++; if (count !== N_PIXELS) begin errors++; $display("[TB] FAIL stream_count: got %0d required %0d", count, N_PIXELS); end
                checks++; if (BUSY !== 1'b0)      begin errors++; $display("[TB] FAIL stream_done_busy: got %b required 0", BUSY); end
                checks++; if (PIX_VALID !== 1'b0) begin errors++; $display("[TB] FAIL stream_done_valid: got %b required 0", PIX_VALID); end
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL stream_done_seen: got %0d required 1", done_cnt); end
        step();
        checks++; if (IMG_DONE !== 1'b0) begin errors++; $display("[TB] FAIL stream_done_pulse: got %b required 0", IMG_DONE); end
        PIX_READY = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        int count;
        int done_cnt;
        logic stalled;
        logic [IDX_W-1:0]   prev_idx;
        logic [PIXEL_W-1:0] prev_data;
        logic               prev_last;
        PIX_READY = 1'b0;
        axi_write(CTRL_ADDR, 32'h0000_0001, 4'hF, resp);
        checks++; if (resp !== 2'b00) begin errors++; $display("[TB] FAIL bp_start_resp: got %b required 00", resp); end
        count    = 0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
            if (PIX_VALID) begin
                checks++; if (PIX_IDX !== 8'(count)) begin errors++; $display("[TB] FAIL bp_idx: got %0d required %0d", PIX_IDX, count); end
                checks++; if (PIX_DATA !== exp_mem[count % N_PIXELS]) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h required %h", count, PIX_DATA, exp_mem[count % N_PIXELS]); end
            end
            PIX_READY = 1'($urandom_range(0, 1));
            stalled   = PIX_VALID && !PIX_READY;
            prev_idx  = PIX_IDX;
            prev_data = PIX_DATA;
            prev_last = PIX_LAST;
            if (PIX_VALID && PIX_READY) count++;
            step();
            if (stalled) begin
                checks++;
                if (PIX_VALID !== 1'b1 || PIX_IDX !== prev_idx || PIX_DATA !== prev_data || PIX_LAST !== prev_last) begin
                    errors++;
                    $display("[TB] FAIL bp_stall_stable: got v=%b idx=%0d data=%h last=%b required v=1 idx=%0d data=%h last=%b",
                             PIX_VALID, PIX_IDX, PIX_DATA, PIX_LAST, prev_idx, prev_data, prev_last);
                end
            end
            if (IMG_DONE) done_cnt++;
        end
        checks++; if (done_cnt !== 1)   begin errors++; $display("[TB] FAIL bp_done_seen: got %0d required 1", done_cnt); end
        checks++; if (count !== N_PIXELS) begin errors++; $display("[TB] FAIL bp_count: got %0d required %0d", count, N_PIXELS); end
        PIX_READY = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp;
        logic found;
        PIX_READY = 1'b0;
        axi_write(CTRL_ADDR, 32'h0000_0001, 4'hF, resp);
        checks++; if (resp !== 2'b00) begin errors++; $display("[TB] FAIL b2b_start_resp: got %b required 00", resp); end
        PIX_READY = 1'b1;
        found     = 1'b0;
        for (int cyc = 0; cyc < 400 && !found; cyc++) begin
            if (PIX_VALID && PIX_IDX == 8'd255) found = 1'b1;
            else step();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL b2b_reach_last: got %b required 1", found); end
        // Present a CTRL start alongside the last pixel handshake so it commits with IMG_DONE
        AWADDR  = CTRL_ADDR;
        WDATA   = 32'h0000_0001;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = 1'b1;
        step();
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        PIX_READY = 1'b0;
        checks++; if (IMG_DONE !== 1'b1) begin errors++; $display("[TB] FAIL b2b_img_done: got %b required 1", IMG_DONE); end
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("[TB] FAIL b2b_busy_low: got %b required 0", BUSY); end
        checks++; if (BVALID !== 1'b0)   begin errors++; $display("[TB] FAIL b2b_commit_cycle: got %b required 0", BVALID); end
        step();
        checks++; if (BVALID !== 1'b1)   begin errors++; $display("[TB] FAIL b2b_bvalid: got %b required 1", BVALID); end
        checks++; if (BRESP !== 2'b00)   begin errors++; $display("[TB] FAIL b2b_bresp: got %b required 00", BRESP); end
        checks++; if (BUSY !== 1'b1)     begin errors++; $display("[TB] FAIL b2b_restart_busy: got %b required 1", BUSY); end
        checks++; if (PIX_VALID !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_valid: got %b required 1", PIX_VALID); end
        checks++; if (PIX_IDX !== 8'd0)  begin errors++; $display("[TB] FAIL b2b_restart_idx: got %0d required 0", PIX_IDX); end
        checks++; if (IMG_DONE !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_single: got %b required 0", IMG_DONE); end
        step();
        BREADY = 1'b0;
    endtask

    task automatic test_busy_protect();
        logic [1:0] resp;
        // Stream is running and stalled at index 0
        axi_write(32'h0000_0000, 32'h0000_00EE, 4'hF, resp);
        checks++; if (resp !== 2'b10) begin errors++; $display("[TB] FAIL busy_pix_resp: got %b required 10", resp); end
        axi_write(CTRL_ADDR, 32'h0000_0001, 4'hF, resp);
        checks++; if (resp !== 2'b10) begin errors++; $display("[TB] FAIL busy_ctrl_resp: got %b required 10", resp); end
        checks++; if (BUSY !== 1'b1)  begin errors++; $display("[TB] FAIL busy_still_busy: got %b required 1", BUSY); end
        checks++; if (PIX_IDX !== 8'd0) begin errors++; $display("[TB] FAIL busy_idx: got %0d required 0", PIX_IDX); end
        checks++; if (PIX_DATA !== exp_mem[0]) begin errors++; $display("[TB] FAIL busy_mem_intact: got %h required %h", PIX_DATA, exp_mem[0]); end
    endtask

    task automatic test_mid_stream_reset();
        logic found;
        PIX_READY = 1'b1;
        found     = 1'b0;
        for (int cyc = 0; cyc < 300 && !found; cyc++) begin
            if (PIX_VALID && PIX_IDX == 8'd100) found = 1'b1;
            else step();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL rst_reach_100: got %b required 1", found); end
        ARESET = 1'b1;
        step();
        checks++; if (PIX_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_valid: got %b required 0", PIX_VALID); end
        checks++; if (BUSY !== 1'b0)      begin errors++; $display("[TB] FAIL rst_busy: got %b required 0", BUSY); end
        checks++; if (IMG_DONE !== 1'b0)  begin errors++; $display("[TB] FAIL rst_img_done: got %b required 0", IMG_DONE); end
        ARESET    = 1'b0;
        PIX_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (IMG_DONE !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_done[%0d]: got %b required 0", i, IMG_DONE); end
        end
    endtask

    task automatic test_after_reset();
        logic [1:0] resp;
        // Memory is untouched by reset, so a fresh stream replays the stored image
        axi_write(CTRL_ADDR, 32'h0000_0001, 4'hF, resp);
        checks++; if (resp !== 2'b00) begin errors++; $display("[TB] FAIL post_rst_resp: got %b required 00", resp); end
        PIX_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (PIX_IDX !== 8'(i)) begin errors++; $display("[TB] FAIL post_rst_idx: got %0d required %0d", PIX_IDX, i); end
            checks++; if (PIX_DATA !== exp_mem[i]) begin errors++; $display("[TB] FAIL post_rst_data[%0d]: got %h required %h", i, PIX_DATA, exp_mem[i]); end
            step();
        end
        PIX_READY = 1'b0;
        ARESET    = 1'b1;
        step();
        ARESET = 1'b0;
        step();
    endtask

    // Scenario sequence
    initial begin
        ARESET    = 1'b1;
        AWADDR    = '0;
        AWPROT    = 3'b000;
        AWVALID   = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        PIX_READY = 1'b0;
        test_reset();
        test_fill();
        test_independent_channels();
        test_strobe_illegal();
        test_full_stream();
        test_backpressure();
        test_back_to_back();
        test_busy_protect();
        test_mid_stream_reset();
        test_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
